// File: rtl/inst_pkg.sv
// ----------------------------------------------------------------------------
// inst_pkg
// Shared definitions for the decode stage: opcode values, register field
// slot indices, the decoded control-flag struct and the decoder FSM states.
// Optional feature macro used by the importers: ILLEGAL_OP_EN.
// ----------------------------------------------------------------------------
package inst_pkg;

    // Opcode values
    localparam int OP_NOP     = 0;
    localparam int OP_WRITE   = 1;
    localparam int OP_JMP     = 2;
    localparam int OP_JMP_Z   = 3;
    localparam int OP_JMP_NZ  = 4;
    localparam int OP_ADD     = 5;
    localparam int OP_SUB     = 6;
    localparam int OP_AND     = 7;
    localparam int OP_NOP_ALT = 8;
    localparam int OP_MOV     = 9;
    localparam int OP_MOV_REG = 10;
    localparam int OP_STORE   = 11;
    localparam int OP_LOAD    = 12;

    // Register field slots below the opcode, counted in REG_W units from the LSB.
    // The instruction reads {op, rd, rs, rt} from MSB to LSB.
    localparam int FIELD_RD = 2;
    localparam int FIELD_RS = 1;
    localparam int FIELD_RT = 0;

    typedef struct packed {
        logic write;
        logic jump;
        logic mov;
        logic mov_reg;
        logic store;
        logic load;
        logic illegal;
    } dec_flags_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HAZARD = 2'd1,
        ST_SHADOW = 2'd2
    } dec_state_t;

endpackage

// File: rtl/inst_ctrl_rom.sv
// ----------------------------------------------------------------------------
// inst_ctrl_rom
// Pure combinational opcode -> control-flag table.
// Optional feature macro: ILLEGAL_OP_EN (opcodes above OP_LOAD raise illegal
// with every other strobe low; without it they decode as NOPs).
// Ports:
//   i_op     in   OP_W   opcode
//   o_flags  out  struct decoded control strobes
// ----------------------------------------------------------------------------
module inst_ctrl_rom
    import inst_pkg::*;
#(
    parameter int OP_W = 4
) (
    input  logic [OP_W-1:0] i_op,
    output dec_flags_t      o_flags
);

    always_comb begin
        o_flags = '0;
        case (int'(i_op))
            OP_WRITE, OP_ADD, OP_SUB, OP_AND: begin
                o_flags.write = 1'b1;
            end
            OP_JMP, OP_JMP_Z, OP_JMP_NZ: begin
                o_flags.jump = 1'b1;
            end
            OP_MOV: begin
                o_flags.write = 1'b1;
                o_flags.mov   = 1'b1;
            end
            OP_MOV_REG: begin
                o_flags.write   = 1'b1;
                o_flags.mov_reg = 1'b1;
            end
            OP_STORE: begin
                o_flags.store = 1'b1;
            end
            OP_LOAD: begin
                o_flags.write = 1'b1;
                o_flags.load  = 1'b1;
            end
            default: begin
`ifdef ILLEGAL_OP_EN
                if (int'(i_op) > OP_LOAD) begin
                    o_flags.illegal = 1'b1;
                end
`endif
            end
        endcase
    end

endmodule

// File: rtl/pipelined_inst_decoder.sv
// ----------------------------------------------------------------------------
// pipelined_inst_decoder
// Registered decode stage. Accepts instructions on a valid/ready handshake,
// presents opcode, {rd,rs,rt} and control strobes one cycle later, inserts a
// bubble on load-use hazards and drops JUMP_SHADOW accepted words after a jump.
// Optional feature macro: ILLEGAL_OP_EN (drives the illegal strobe for
// opcodes above OP_LOAD; otherwise illegal stays 0).
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   in_valid/in_ready/inst upstream handshake and instruction word
//   out_valid/out_ready    downstream handshake
//   op, reg_addr           decoded opcode and {rd,rs,rt}
//   write..load, illegal   control strobes
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | normal decode, hazard check active
// ST_HAZARD | one-cycle bubble, in_ready low, load-use tracking cleared
// ST_SHADOW | accepted words are dropped until the shadow count expires
// ----------------------------------------------------------------------------
module pipelined_inst_decoder
    import inst_pkg::*;
#(
    parameter int INST_W      = 16,
    parameter int OP_W        = 4,
    parameter int REG_W       = 4,
    parameter int JUMP_SHADOW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INST_W-1:0]    inst,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OP_W-1:0]      op,
    output logic [3*REG_W-1:0]   reg_addr,
    output logic                 write,
    output logic                 jump,
    output logic                 mov,
    output logic                 mov_reg,
    output logic                 store,
    output logic                 load,
    output logic                 illegal
);

    localparam logic       SHADOW_EN   = (JUMP_SHADOW > 0);
    localparam logic [2:0] SHADOW_INIT = 3'(JUMP_SHADOW);

    dec_state_t         r_state;
    dec_state_t         w_state_nxt;
    logic               r_out_valid;
    logic [OP_W-1:0]    r_op;
    logic [3*REG_W-1:0] r_reg_addr;
    dec_flags_t         r_flags;
    logic               r_last_load;
    logic [REG_W-1:0]   r_last_rd;
    logic [2:0]         r_shadow_cnt;

    logic [OP_W-1:0]    w_op;
    logic [REG_W-1:0]   w_rd;
    logic [REG_W-1:0]   w_rs;
    logic [REG_W-1:0]   w_rt;
    dec_flags_t         w_flags;
    logic               w_out_free;
    logic               w_hazard;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_load_out;

    assign w_op = inst[INST_W-1 -: OP_W];
    assign w_rd = inst[FIELD_RD*REG_W +: REG_W];
    assign w_rs = inst[FIELD_RS*REG_W +: REG_W];
    assign w_rt = inst[FIELD_RT*REG_W +: REG_W];

    inst_ctrl_rom #(
        .OP_W (OP_W)
    ) u_rom (
        .i_op    (w_op),
        .o_flags (w_flags)
    );

    assign w_out_free = !r_out_valid || out_ready;
    assign w_hazard   = r_last_load && in_valid && ((w_rs == r_last_rd) || (w_rt == r_last_rd));
    assign w_accept   = in_valid && w_in_ready;
    // Only words accepted in RUN reach the output; SHADOW accepts are dropped.
    assign w_load_out = w_accept && (r_state == ST_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_in_ready = w_out_free && !w_hazard;
                if (w_hazard && w_out_free) begin
                    w_state_nxt = ST_HAZARD;
                end else if (in_valid && w_in_ready && w_flags.jump && SHADOW_EN) begin
                    w_state_nxt = ST_SHADOW;
                end
            end
            ST_HAZARD: begin
                w_state_nxt = ST_RUN;
            end
            ST_SHADOW: begin
                w_in_ready = w_out_free;
                if (in_valid && w_out_free && (r_shadow_cnt == 3'd1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_op         <= '0;
            r_reg_addr   <= '0;
            r_flags      <= '0;
            r_last_load  <= 1'b0;
            r_last_rd    <= '0;
            r_shadow_cnt <= '0;
        end else begin
            if (w_load_out) begin
                r_out_valid <= 1'b1;
                r_op        <= w_op;
                r_reg_addr  <= inst[3*REG_W-1:0];
                r_flags     <= w_flags;
                r_last_load <= w_flags.load;
                r_last_rd   <= w_rd;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (r_state == ST_HAZARD) begin
                r_last_load <= 1'b0;
            end

            if (w_load_out && w_flags.jump && SHADOW_EN) begin
                r_shadow_cnt <= SHADOW_INIT;
            end else if ((r_state == ST_SHADOW) && w_accept) begin
                r_shadow_cnt <= r_shadow_cnt - 3'd1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign op        = r_op;
    assign reg_addr  = r_reg_addr;
    assign write     = r_flags.write;
    assign jump      = r_flags.jump;
    assign mov       = r_flags.mov;
    assign mov_reg   = r_flags.mov_reg;
    assign store     = r_flags.store;
    assign load      = r_flags.load;
    assign illegal   = r_flags.illegal;

endmodule

// File: tb/tb_pipelined_inst_decoder.sv
module tb_pipelined_inst_decoder;

    localparam int INST_W = 16;
    localparam int OP_W   = 4;
    localparam int REG_W  = 4;
    localparam int JS     = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] inst;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  op;
    logic [11:0] reg_addr;
    logic        write, jump, mov, mov_reg, store, load, illegal;

    always #5 clk = ~clk;

    pipelined_inst_decoder #(
        .INST_W      (INST_W),
        .OP_W        (OP_W),
        .REG_W       (REG_W),
        .JUMP_SHADOW (JS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst      (inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op        (op),
        .reg_addr  (reg_addr),
        .write     (write),
        .jump      (jump),
        .mov       (mov),
        .mov_reg   (mov_reg),
        .store     (store),
        .load      (load),
        .illegal   (illegal)
    );

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: "mode" is what the decoder is currently doing, in words.
    typedef enum int {M_NORMAL, M_BUBBLE, M_SQUASH} mode_t;
    mode_t      m_mode;
    int         m_left;
    bit         m_last_load;
    int         m_last_rd;
    bit         m_ov;
    int         m_op;
    int         m_regs;
    bit [6:0]   m_flags;      // {write,jump,mov,mov_reg,store,load,illegal}
    bit         seen_squashed;

    function automatic bit [6:0] ref_flags(input int o);
        bit w, j, mv, mr, st, ld, il;
        w  = o inside {1, 5, 6, 7, 9, 10, 12};
        j  = o inside {2, 3, 4};
        mv = (o == 9);
        mr = (o == 10);
        st = (o == 11);
        ld = (o == 12);
        il = 1'b0;
`ifdef ILLEGAL_OP_EN
        il = (o > 12);
`endif
        return {w, j, mv, mr, st, ld, il};
    endfunction

    task automatic model_reset();
        m_mode      = M_NORMAL;
        m_left      = 0;
        m_last_load = 0;
        m_last_rd   = 0;
        m_ov        = 0;
        m_op        = 0;
        m_regs      = 0;
        m_flags     = '0;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, check the DUT against the model, advance both.
    task automatic cyc(input bit r, input bit v, input logic [15:0] w, input bit ordy);
        int  o, rd, rs, rt;
        bit  free, haz, rdy, acc, loaded;
        rst = r; in_valid = v; inst = w; out_ready = ordy;
        #1;
        o  = int'(w[15:12]);
        rd = int'(w[11:8]);
        rs = int'(w[7:4]);
        rt = int'(w[3:0]);
        free = !m_ov || ordy;
        haz  = (m_mode == M_NORMAL) && m_last_load && v && (rs == m_last_rd || rt == m_last_rd);
        case (m_mode)
            M_NORMAL: rdy = free && !haz;
            M_SQUASH: rdy = free;
            default:  rdy = 1'b0;
        endcase
        check_val("in_ready", 32'(in_ready), 32'(rdy));
        check_val("out_valid", 32'(out_valid), 32'(m_ov));
        check_val("op", 32'(op), 32'(m_op));
        check_val("reg_addr", 32'(reg_addr), 32'(m_regs));
        check_val("flags", 32'({write, jump, mov, mov_reg, store, load, illegal}), 32'(m_flags));
        if (out_valid && op == 4'h1 && reg_addr == 12'h111) seen_squashed = 1;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            acc    = v && rdy;
            loaded = 0;
            case (m_mode)
                M_NORMAL: begin
                    if (haz && free) begin
                        m_mode = M_BUBBLE;
                    end else if (acc) begin
                        loaded      = 1;
                        m_op        = o;
                        m_regs      = int'(w[11:0]);
                        m_flags     = ref_flags(o);
                        m_last_load = (o == 12);
                        m_last_rd   = rd;
                        if (o inside {2, 3, 4} && JS > 0) begin
                            m_mode = M_SQUASH;
                            m_left = JS;
                        end
                    end
                end
                M_BUBBLE: begin
                    m_last_load = 0;
                    m_mode      = M_NORMAL;
                end
                default: begin
                    if (acc) begin
                        m_left--;
                        if (m_left == 0) m_mode = M_NORMAL;
                    end
                end
            endcase
            if (loaded) m_ov = 1;
            else if (ordy) m_ov = 0;
        end
        #1;
    endtask

    initial begin
        rst = 1; in_valid = 0; inst = '0; out_ready = 0;
        seen_squashed = 0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // reset state
        cyc(1, 0, 16'h0000, 0);
        cyc(0, 0, 16'h0000, 1);

        // streaming write, mov, mov_reg, store
        cyc(0, 1, 16'h1123, 1);
        cyc(0, 1, 16'h9456, 1);
        cyc(0, 1, 16'hA789, 1);
        cyc(0, 1, 16'hB0AB, 1);
        cyc(0, 0, 16'h0000, 1);
        cyc(0, 0, 16'h0000, 1);

        // load-use bubble
        cyc(0, 1, 16'hC300, 1);
        repeat (4) cyc(0, 1, 16'h1031, 1);
        cyc(0, 0, 16'h0000, 1);
        cyc(0, 0, 16'h0000, 1);

        // jump shadow: 0x1111 is dropped
        cyc(0, 1, 16'h2000, 1);
        cyc(0, 1, 16'h1111, 1);
        cyc(0, 1, 16'h5222, 1);
        cyc(0, 0, 16'h0000, 1);
        cyc(0, 0, 16'h0000, 1);
        check_val("shadow_drop", 32'(seen_squashed), 32'd0);

        // downstream stall holds outputs
        cyc(0, 1, 16'h9ABC, 0);
        repeat (3) cyc(0, 1, 16'h5DEF, 0);
        cyc(0, 1, 16'h5DEF, 1);
        cyc(0, 0, 16'h0000, 1);

        // reset while in shadow with a word pending
        cyc(0, 1, 16'h2345, 1);
        cyc(1, 0, 16'h0000, 0);
        cyc(0, 0, 16'h0000, 1);

        // out-of-range opcode
        cyc(0, 1, 16'hE123, 1);
        cyc(0, 0, 16'h0000, 1);
        cyc(0, 1, 16'hF000, 0);
        cyc(0, 0, 16'h0000, 1);

        // randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 600; i++) begin
            logic [15:0] w;
            bit r, v, ordy;
            w[15:12] = 4'($urandom_range(15, 0));
            w[11:8]  = 4'($urandom_range(3, 0));
            w[7:4]   = 4'($urandom_range(3, 0));
            w[3:0]   = 4'($urandom_range(3, 0));
            if ($urandom_range(3, 0) == 0) w[15:12] = 4'd12;
            r    = ($urandom_range(49, 0) == 0);
            v    = ($urandom_range(3, 0) != 0);
            ordy = ($urandom_range(9, 0) < 7);
            cyc(r, v, w, ordy);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
